// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak sponge front-end
package keccak_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [24:0] state_t;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    PERM,
    SQUEEZE
  } sponge_state_e;

  localparam int         SHA3_256_RATE_LANES = 17;
  localparam logic [7:0] PAD_FINAL_BYTE      = 8'h80;
  localparam logic [7:0] DOMAIN_SHA3         = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE        = 8'h1F;

  // Keep the low nbytes bytes of a lane; counts above 8 keep the whole lane.
  function automatic lane_t byte_mask(input logic [3:0] nbytes);
    lane_t m;
    for (int b = 0; b < 8; b++) begin
      m[b*8 +: 8] = (4'(b) < nbytes) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/keccak_pad_mask.sv
// rtl/keccak_pad_mask.sv - combinational multi-rate padding XOR mask over the rate lanes
module keccak_pad_mask
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = SHA3_256_RATE_LANES
) (
  input  logic [4:0]              pad_lane,
  input  logic [2:0]              pad_byte,
  input  logic [7:0]              domain,
  output logic [RATE_LANES*64-1:0] mask
);

  // Domain byte at the pad position; final bit at the top byte of the last rate lane.
  // When both land on the same byte they combine (e.g. 8'h86).
  always_comb begin
    mask = '0;
    for (int i = 0; i < RATE_LANES; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (pad_lane == 5'(i) && pad_byte == 3'(b)) begin
          mask[i*64 + b*8 +: 8] = domain;
        end
      end
    end
    mask[(RATE_LANES-1)*64 + 56 +: 8] = mask[(RATE_LANES-1)*64 + 56 +: 8] ^ PAD_FINAL_BYTE;
  end

endmodule

// File: rtl/keccak_sponge_absorb.sv
// rtl/keccak_sponge_absorb.sv - SHA-3 sponge absorb/pad/squeeze front-end for Keccak-f[1600]
module keccak_sponge_absorb
  import keccak_pkg::*;
#(
  parameter int         RATE_LANES = SHA3_256_RATE_LANES,
  parameter int         OUT_LANES  = 4,
  parameter logic [7:0] DOMAIN     = DOMAIN_SHA3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  input  logic              in_last,
  input  logic [3:0]        in_bytes,
  output logic              perm_start,
  output logic [24:0][63:0] perm_state,
  input  logic [24:0][63:0] perm_result,
  input  logic              perm_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_last
);

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
  localparam logic [4:0] RATE_END  = 5'(RATE_LANES);
  localparam logic [4:0] LAST_OUT  = 5'(OUT_LANES - 1);

  sponge_state_e fsm_q, fsm_d;
  state_t        state_q, state_d;
  logic [4:0]    lane_idx_q, lane_idx_d;
  logic [2:0]    pad_byte_q, pad_byte_d;
  logic [4:0]    sq_idx_q, sq_idx_d;
  logic          pending_pad_q, pending_pad_d;
  logic          final_q, final_d;
  logic          perm_busy_q, perm_busy_d;
  logic [RATE_LANES*64-1:0] pad_mask;
  lane_t         masked_data;

  // In PAD, lane_idx/pad_byte hold the recorded pad position.
  keccak_pad_mask #(
    .RATE_LANES(RATE_LANES)
  ) u_pad_mask (
    .pad_lane(lane_idx_q),
    .pad_byte(pad_byte_q),
    .domain  (DOMAIN),
    .mask    (pad_mask)
  );

  assign masked_data = in_last ? (in_data & byte_mask(in_bytes)) : in_data;
  assign perm_state  = state_q;

  // Register all sponge state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm_q         <= ABSORB;
      state_q       <= '0;
      lane_idx_q    <= '0;
      pad_byte_q    <= '0;
      sq_idx_q      <= '0;
      pending_pad_q <= 1'b0;
      final_q       <= 1'b0;
      perm_busy_q   <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      lane_idx_q    <= lane_idx_d;
      pad_byte_q    <= pad_byte_d;
      sq_idx_q      <= sq_idx_d;
      pending_pad_q <= pending_pad_d;
      final_q       <= final_d;
      perm_busy_q   <= perm_busy_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    lane_idx_d    = lane_idx_q;
    pad_byte_d    = pad_byte_q;
    sq_idx_d      = sq_idx_q;
    pending_pad_d = pending_pad_q;
    final_d       = final_q;
    perm_busy_d   = 1'b0;
    in_ready      = 1'b0;
    perm_start    = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;

    case (fsm_q)
      ABSORB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d[lane_idx_q] = state_q[lane_idx_q] ^ masked_data;
          if (in_last) begin
            if (in_bytes >= 4'd8) begin
              lane_idx_d = lane_idx_q + 5'd1;
              pad_byte_d = 3'd0;
            end else begin
              pad_byte_d = in_bytes[2:0];
            end
            fsm_d = PAD;
          end else if (lane_idx_q == LAST_LANE) begin
            lane_idx_d = '0;
            fsm_d      = PERM;
          end else begin
            lane_idx_d = lane_idx_q + 5'd1;
          end
        end
      end

      PAD: begin
        if (lane_idx_q == RATE_END) begin
          // Message filled the block exactly: permute it, then pad a fresh block.
          pending_pad_d = 1'b1;
          lane_idx_d    = '0;
          pad_byte_d    = '0;
        end else begin
          for (int i = 0; i < RATE_LANES; i++) begin
            state_d[i] = state_q[i] ^ pad_mask[i*64 +: 64];
          end
          final_d = 1'b1;
        end
        fsm_d = PERM;
      end

      PERM: begin
        perm_start  = !perm_busy_q;
        perm_busy_d = 1'b1;
        if (perm_done) begin
          state_d     = perm_result;
          perm_busy_d = 1'b0;
          if (pending_pad_q) begin
            pending_pad_d = 1'b0;
            fsm_d         = PAD;
          end else if (final_q) begin
            sq_idx_d = '0;
            fsm_d    = SQUEEZE;
          end else begin
            fsm_d = ABSORB;
          end
        end
      end

      SQUEEZE: begin
        out_valid = 1'b1;
        out_data  = state_q[sq_idx_q];
        out_last  = (sq_idx_q == LAST_OUT);
        if (out_ready) begin
          if (sq_idx_q == LAST_OUT) begin
            state_d    = '0;
            lane_idx_d = '0;
            final_d    = 1'b0;
            sq_idx_d   = '0;
            fsm_d      = ABSORB;
          end else begin
            sq_idx_d = sq_idx_q + 5'd1;
          end
        end
      end

      default: fsm_d = ABSORB;
    endcase

    if (!rstn) begin
      in_ready   = 1'b0;
      perm_start = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
    end
  end

endmodule

// File: doc/keccak_sponge_absorb.md
Name: keccak_sponge_absorb

Overview:
- Sponge front-end that sits directly upstream of the Keccak-f[1600] state permutation.
- Accepts a message as 64-bit little-endian lanes over a valid/ready stream and XORs each lane into the rate portion of a 25-lane state.
- Applies SHA-3 multi-rate padding with a domain suffix, then hands the state to the permutation through a start/done handshake.
- After the final permutation, streams out the first OUT_LANES lanes as the digest.

Parameters:
- RATE_LANES, 17, rate in 64-bit lanes (17 = SHA3-256). Legal range 1..24.
- OUT_LANES, 4, digest lanes squeezed. Must satisfy OUT_LANES <= RATE_LANES; no extra squeeze permutations.
- DOMAIN, 8'h06, domain-separation suffix byte (8'h1F for SHAKE).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  message lane valid
- in_ready  out  1  block accepts a lane
- in_data  in  64  message lane, byte 0 in bits [7:0]
- in_last  in  1  final lane of the message
- in_bytes  in  4  valid bytes in the final lane (0..8, values >8 treated as 8); ignored unless in_last
- perm_start  out  1  one-cycle pulse requesting a permutation
- perm_state  out  64 x [24:0]  state presented to the permutation; stable from perm_start until perm_done
- perm_result  in  64 x [24:0]  permuted state
- perm_done  in  1  perm_result valid this cycle
- out_valid  out  1  digest lane valid
- out_ready  in  1  sink accepts the digest lane
- out_data  out  64  digest lane
- out_last  out  1  final digest lane

Behaviour:
- Reset (rstn=0 at posedge):
  - state lanes, lane_idx, sq_idx, pending_pad and final are all cleared to 0.
  - FSM goes to ABSORB.
  - perm_start=0, out_valid=0, out_last=0, out_data=0, in_ready=0 in the reset cycle.
  - Reset mid-operation aborts everything. A perm_done arriving later, outside PERM, is ignored.
- FSM states: ABSORB, PAD, PERM, SQUEEZE.
- ABSORB (in_ready=1):
  - Non-last handshake: state[lane_idx] ^= in_data and lane_idx++. If lane_idx was RATE_LANES-1, clear lane_idx and go to PERM.
  - Last handshake: XOR in_data masked to its low in_bytes bytes into state[lane_idx], then record the pad position:
    - in_bytes<8: pad at (lane_idx, in_bytes).
    - in_bytes=8: pad at (lane_idx+1, 0).
  - After a last handshake, go to PAD.
- PAD (single cycle, in_ready=0):
  - If the pad lane equals RATE_LANES: set pending_pad=1, set the pad position to (0,0), and go to PERM.
  - Otherwise: XOR DOMAIN into the pad byte, XOR 8'h80 into byte 7 of lane RATE_LANES-1, set final=1, and go to PERM.
  - When the two pad bytes coincide, both XORs apply (e.g. 8'h86).
- PERM (in_ready=0):
  - perm_start is high exactly on the first cycle in PERM.
  - perm_state is driven from the registered state throughout.
  - On perm_done: state <= perm_result, then:
    - if pending_pad: clear pending_pad, go to PAD;
    - else if final: go to SQUEEZE with sq_idx=0;
    - else: go to ABSORB.
  - perm_done on the same cycle as perm_start is legal and accepted.
- SQUEEZE (in_ready=0):
  - out_valid=1, out_data=state[sq_idx], out_last=(sq_idx==OUT_LANES-1).
  - out_data and out_last are held stable while out_ready=0.
  - On handshake: sq_idx++.
  - On the last handshake: clear state, lane_idx and final, and return to ABSORB. in_ready rises the next cycle.
- Latency: one permutation per RATE_LANES lanes, plus PAD (1 cycle) and one extra permutation when the message ends exactly on a block boundary with in_bytes=8.
- The permutation interface does not use the unpacked-array self-assignment style. state is the block's only storage; perm_state is a continuous copy of it.

Decomposition:
- Package keccak_pkg:
  - lane_t (logic [63:0]) and state_t (lane_t [24:0]);
  - sponge FSM enum;
  - constants SHA3_256_RATE_LANES=17 and PAD_FINAL_BYTE=8'h80;
  - DOMAIN_SHA3=8'h06 and DOMAIN_SHAKE=8'h1F.
- One natural sub-module: keccak_pad_mask. It is combinational and, given lane_idx, byte position and DOMAIN, produces the 1088-bit rate XOR mask. This keeps the FSM file small.

Test Plan (bench pairs the DUT with a golden Keccak-f[1600] model on the perm_* ports, with 0-5 cycle random done latency):
- Empty message: one lane, in_last=1, in_bytes=0.
  - At perm_start: perm_state lane0=64'h06 and lane16=64'h8000000000000000.
  - Digest lane0 = 64'h66d71ebff8c6ffa7 (SHA3-256 "" = a7ffc6f8...).
- "abc": in_data=64'h0000000000636261, in_bytes=3, in_last.
  - At perm_start: lane0=64'h0000000006636261.
  - Digest lanes = 3a985da74fe225b2... (lane0 = 64'hb225e24fa75d983a).
  - out_last only on the 4th lane.
- 135-byte message (16 full lanes + last lane, in_bytes=7):
  - Exactly one perm_start.
  - Byte 7 of lane16 equals data XOR 8'h86 at perm_start.
- 136-byte message (17 full lanes, in_bytes=8):
  - Exactly two perm_start pulses.
  - The second perm_state has lane0 ^= 8'h06 and lane16 ^= 8'h80<<56 applied on the permuted state.
- Backpressure and reset:
  - out_ready toggled 1010...: each lane is held stable and counted once; 4 handshakes occur, then in_ready=1.
  - rstn pulled low mid-PERM followed by a stray perm_done: state stays 0, no out_valid, and the next message hashes correctly.
